test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
- Runs a programmed list of memory-checker tests back to back without host involvement between tests.
- Holds up to DEPTH test-parameter entries, each a pair of 32-bit words in the same format as the checker's test_param_reg. For each entry it drives the parameters and a start pulse into the checker control path, waits for the result-write strobe, and records pass/fail.
- Sits between the CSR block and the checker control block, replacing the direct CSR start/param path when sequence mode is used.

Parameters:
DEPTH, 8, number of parameter entries (power of 2, >= 2)
IDX_W, $clog2(DEPTH), entry index width
TIMEOUT_W, 24, watchdog counter width per test

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
cfg_wr_i  input  1  write strobe for the entry table
cfg_idx_i  input  IDX_W  entry index for the write
cfg_word_i  input  1  word select: 0 = param word 1, 1 = param word 2
cfg_data_i  input  32  data for the write
seq_len_i  input  IDX_W+1  number of entries to run, sampled at start
seq_start_i  input  1  start-sequence pulse
seq_abort_i  input  1  stop after the current test
start_test_o  output  1  one-cycle start pulse to the checker
test_param_reg_o  output  [2:1][31:0]  current entry parameters to the checker
wr_result_i  input  1  checker result-write strobe (test finished)
test_result_i  input  1  checker result, 1 = error; valid when wr_result_i = 1
busy_o  output  1  sequence in progress
done_o  output  1  one-cycle pulse when the sequence ends
cur_idx_o  output  IDX_W  index of the entry in progress
fail_map_o  output  DEPTH  bit i set = entry i failed or timed out
fail_cnt_o  output  IDX_W+1  number of failed entries
timeout_o  output  1  sticky: at least one test hit the watchdog
aborted_o  output  1  sticky: last sequence was aborted

Behaviour:
- Reset: state IDLE. All outputs 0, including test_param_reg_o. The entry table is not reset.
- Entry table: write on cfg_wr_i only in IDLE; writes while busy_o = 1 are dropped.
- FSM states: IDLE, LOAD, START, WAIT, NEXT, DONE.
- IDLE:
  - seq_start_i = 1 and seq_abort_i = 0: latch len = min(seq_len_i, DEPTH); clear fail_map_o, fail_cnt_o, timeout_o and aborted_o; set idx to 0.
  - If len = 0, go to DONE; otherwise go to LOAD.
  - seq_start_i and seq_abort_i high together: start ignored, stay in IDLE.
- LOAD (1 cycle): test_param_reg_o <= table[idx]; cur_idx_o <= idx; go to START. Parameters are therefore stable at least 1 cycle before start_test_o.
- START (1 cycle): start_test_o = 1; clear the watchdog counter; go to WAIT.
- WAIT: watchdog increments each cycle.
  - wr_result_i = 1: record test_result_i for idx; go to NEXT.
  - Watchdog reaches all-ones before wr_result_i: record a fail for idx, set timeout_o, go to NEXT.
  - A later stray wr_result_i outside WAIT is ignored.
- Recording a fail sets fail_map_o[idx] and increments fail_cnt_o.
- test_param_reg_o holds its value from LOAD through WAIT and NEXT. It never changes while a test runs, because the checker decodes the mode fields combinationally for the whole test.
- NEXT (1 cycle):
  - If abort is pending, or idx = len-1: go to DONE.
  - Otherwise: idx++; go to LOAD.
- seq_abort_i in LOAD, START, WAIT or NEXT: latch abort-pending and set aborted_o.
  - The current test always runs to completion or timeout; no new start is issued.
  - Abort during LOAD still proceeds through START, since the test parameters are already committed.
- DONE (1 cycle): done_o = 1; clear abort-pending; go to IDLE. test_param_reg_o keeps the last entry.
- busy_o = 1 in every state except IDLE.
- Latency:
  - seq_start_i at cycle T -> LOAD at T+1, start_test_o at T+2.
  - wr_result_i at cycle W -> NEXT at W+1, next start_test_o at W+3.
  - After the last test: done_o at W+2.
- fail_cnt_o cannot overflow (max DEPTH). idx never wraps because len <= DEPTH.
- rst_i mid-sequence returns to IDLE the next cycle with all outputs 0. The checker is reset by the same rst_i.

Test Plan:
- Program entries 0..2 and set seq_len = 3. Bench answers each start after 50 cycles with results 0, 1, 0 -> three start pulses, each 2 cycles after the previous NEXT; done_o once; fail_map = 3'b010; fail_cnt = 1; params equal table[i] from LOAD until wr_result.
- seq_len = 0 -> no start_test_o; done_o at T+1; busy_o high for exactly 1 cycle.
- seq_len = 12 with DEPTH = 8 -> exactly 8 tests run; cur_idx_o ends at 7.
- Bench withholds wr_result for entry 1 (TIMEOUT_W = 6) -> after 63 WAIT cycles: fail_map[1] = 1, timeout_o = 1; the sequence continues to entry 2.
- Assert seq_abort_i during WAIT of entry 1 of 4 -> entry 1 completes; no further start; done_o; aborted_o = 1.
- cfg_wr_i while busy_o = 1 -> table unchanged. seq_start_i while busy_o = 1 -> ignored. seq_start_i with seq_abort_i in IDLE -> stays IDLE. rst_i in WAIT -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/test_sequencer.sv
// Runs a programmed list of memory-checker tests back to back, recording pass/fail per entry.
// Drives the checker's start/param path and watches its result strobe with a per-test watchdog.
module test_sequencer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned IDX_W     = $clog2(DEPTH),
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_wr_i,
    input  logic [IDX_W-1:0]      cfg_idx_i,
    input  logic                  cfg_word_i,
    input  logic [31:0]           cfg_data_i,
    input  logic [IDX_W:0]        seq_len_i,
    input  logic                  seq_start_i,
    input  logic                  seq_abort_i,
    output logic                  start_test_o,
    output logic [2:1][31:0]      test_param_reg_o,
    input  logic                  wr_result_i,
    input  logic                  test_result_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IDX_W-1:0]      cur_idx_o,
    output logic [DEPTH-1:0]      fail_map_o,
    output logic [IDX_W:0]        fail_cnt_o,
    output logic                  timeout_o,
    output logic                  aborted_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StNext,
        StDone
    } state_e;

    localparam logic [IDX_W:0]       LenMax   = (IDX_W + 1)'(DEPTH);
    // Watchdog fires on the cycle its count would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] WdogLast = {{(TIMEOUT_W - 1){1'b1}}, 1'b0};

    state_e               state;
    logic [IDX_W:0]       len;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic                 abort_pend;
    logic [TIMEOUT_W-1:0] wdog;
    logic [2:1][31:0]     table_mem [DEPTH];
    logic                 abort_req;
    logic                 rec_fail;
    logic                 wdog_hit;
    logic                 last_entry;

    assign idx_next   = idx + IDX_W'(1);
    assign abort_req  = seq_abort_i && (state inside {StLoad, StStart, StWait, StNext});
    assign wdog_hit   = (state == StWait) && !wr_result_i && (wdog == WdogLast);
    assign rec_fail   = (state == StWait) && ((wr_result_i && test_result_i) || wdog_hit);
    assign last_entry = ({1'b0, idx} == (len - (IDX_W + 1)'(1)));

    // Entry table has no reset; writes only land while idle.
    always_ff @(posedge clk_i) begin
        if (cfg_wr_i && (state == StIdle)) begin
            if (cfg_word_i) begin
                table_mem[cfg_idx_i][2] <= cfg_data_i;
            end else begin
                table_mem[cfg_idx_i][1] <= cfg_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= StIdle;
            len              <= '0;
            idx              <= '0;
            abort_pend       <= 1'b0;
            wdog             <= '0;
            start_test_o     <= 1'b0;
            test_param_reg_o <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            cur_idx_o        <= '0;
            fail_map_o       <= '0;
            fail_cnt_o       <= '0;
            timeout_o        <= 1'b0;
            aborted_o        <= 1'b0;
        end else begin
            start_test_o <= 1'b0;
            done_o       <= 1'b0;

            if (abort_req) begin
                abort_pend <= 1'b1;
                aborted_o  <= 1'b1;
            end

            if (rec_fail) begin
                fail_map_o[idx] <= 1'b1;
                fail_cnt_o      <= fail_cnt_o + (IDX_W + 1)'(1);
            end

            unique case (state)
                StIdle: begin
                    if (seq_start_i && !seq_abort_i) begin
                        len        <= (seq_len_i > LenMax) ? LenMax : seq_len_i;
                        idx        <= '0;
                        fail_map_o <= '0;
                        fail_cnt_o <= '0;
                        timeout_o  <= 1'b0;
                        aborted_o  <= 1'b0;
                        busy_o     <= 1'b1;
                        if (seq_len_i == '0) begin
                            done_o <= 1'b1;
                            state  <= StDone;
                        end else begin
                            // Params appear during LOAD, a cycle ahead of the start pulse.
                            test_param_reg_o <= table_mem[0];
                            cur_idx_o        <= '0;
                            state            <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    start_test_o <= 1'b1;
                    state        <= StStart;
                end
                StStart: begin
                    wdog  <= '0;
                    state <= StWait;
                end
                StWait: begin
                    if (wr_result_i) begin
                        state <= StNext;
                    end else if (wdog_hit) begin
                        timeout_o <= 1'b1;
                        state     <= StNext;
                    end else begin
                        wdog <= wdog + TIMEOUT_W'(1);
                    end
                end
                StNext: begin
                    if (abort_pend || seq_abort_i || last_entry) begin
                        done_o <= 1'b1;
                        state  <= StDone;
                    end else begin
                        idx              <= idx_next;
                        test_param_reg_o <= table_mem[idx_next];
                        cur_idx_o        <= idx_next;
                        state            <= StLoad;
                    end
                end
                StDone: begin
                    abort_pend <= 1'b0;
                    busy_o     <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: directed vector table, hand-written corner sequences and
// randomized runs checked against a sequence-level reference model.
module tb_test_sequencer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TIMEOUT_W = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_wr;
    logic [IDX_W-1:0]     cfg_idx;
    logic                 cfg_word;
    logic [31:0]          cfg_data;
    logic [IDX_W:0]       seq_len;
    logic                 seq_start;
    logic                 seq_abort;
    logic                 start_test;
    logic [2:1][31:0]     test_param_reg;
    logic                 wr_result;
    logic                 test_result;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     cur_idx;
    logic [DEPTH-1:0]     fail_map;
    logic [IDX_W:0]       fail_cnt;
    logic                 timeout;
    logic                 aborted;

    always #5 clk = ~clk;

    test_sequencer #(
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_wr_i         (cfg_wr),
        .cfg_idx_i        (cfg_idx),
        .cfg_word_i       (cfg_word),
        .cfg_data_i       (cfg_data),
        .seq_len_i        (seq_len),
        .seq_start_i      (seq_start),
        .seq_abort_i      (seq_abort),
        .start_test_o     (start_test),
        .test_param_reg_o (test_param_reg),
        .wr_result_i      (wr_result),
        .test_result_i    (test_result),
        .busy_o           (busy),
        .done_o           (done),
        .cur_idx_o        (cur_idx),
        .fail_map_o       (fail_map),
        .fail_cnt_o       (fail_cnt),
        .timeout_o        (timeout),
        .aborted_o        (aborted)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] model_tbl [DEPTH];
    int          resp_delay [DEPTH];  // 0 = never answer (watchdog case)
    bit          resp_res [DEPTH];

    typedef struct {
        int         len;
        int         delay;
        logic [7:0] res;
        int         withhold;
        int         abort_at;
        int         exp_starts;
        logic [7:0] exp_map;
        bit         exp_timeout;
        bit         exp_aborted;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int i, input logic [31:0] w1, input logic [31:0] w2);
        cfg_wr   = 1'b1;
        cfg_idx  = IDX_W'(i);
        cfg_word = 1'b0;
        cfg_data = w1;
        step();
        cfg_word = 1'b1;
        cfg_data = w2;
        step();
        cfg_wr = 1'b0;
        model_tbl[i] = {w2, w1};
    endtask

    function automatic int popcount8(input logic [7:0] v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(v[i]);
        return c;
    endfunction

    // Sequence-level model: which entries run, and which of them count as failed.
    function automatic void model_expect(input int len, input int ab, output int n,
                                         output logic [7:0] map, output bit to, output bit abd);
        n   = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        abd = 1'b0;
        if (ab >= 0 && ab < n) begin
            n   = ab + 1;
            abd = 1'b1;
        end
        map = '0;
        to  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (resp_res[i] || resp_delay[i] == 0) map[i] = 1'b1;
            if (resp_delay[i] == 0) to = 1'b1;
        end
    endfunction

    // Acts as the checker: answers each start per resp_delay/resp_res and times everything.
    task automatic run_seq(input string tag, input int len, input int abort_at, input int exp_starts,
                           input logic [7:0] exp_map, input bit exp_to, input bit exp_ab);
        int          n_start = 0;
        int          n_done = 0;
        int          busy_cyc = 0;
        int          done_cyc = -1;
        int          start_cyc = 0;
        int          resp_cyc = -1;
        int          wait_end = -1;
        int          cur_k = 0;
        int          next_start_exp = 2;
        int          last_wait_end = -1;
        bit          waiting = 1'b0;
        bit          param_bad = 1'b0;
        bit          finished = 1'b0;
        logic [63:0] prev_param = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (busy) busy_cyc++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (start_test) begin
                check({tag, " start_time"}, 64'(cyc), 64'(next_start_exp));
                cur_k = (n_start < int'(DEPTH)) ? n_start : int'(DEPTH) - 1;
                n_start++;
                check({tag, " cur_idx"}, 64'(cur_idx), 64'(cur_k));
                check({tag, " params_at_load"}, prev_param, model_tbl[cur_k]);
                waiting   = 1'b1;
                param_bad = (test_param_reg !== model_tbl[cur_k]);
                start_cyc = cyc;
                resp_cyc  = (resp_delay[cur_k] == 0) ? -1 : cyc + resp_delay[cur_k];
                wait_end  = (resp_delay[cur_k] == 0) ? cyc + 64 : resp_cyc + 1;
            end else if (waiting) begin
                if (test_param_reg !== model_tbl[cur_k]) param_bad = 1'b1;
                if (cyc == wait_end) begin
                    check({tag, " params_stable"}, 64'(param_bad), 64'(0));
                    waiting        = 1'b0;
                    next_start_exp = cyc + 2;
                    last_wait_end  = cyc;
                end
            end
            if (cyc > 0 && !busy && n_done > 0) begin
                finished = 1'b1;
                break;
            end
            prev_param  = test_param_reg;
            seq_start   = (cyc == 0) || (busy && cyc == 6);
            seq_len     = (IDX_W + 1)'(len);
            cfg_wr      = busy && (cyc == 4);
            cfg_idx     = '0;
            cfg_word    = 1'b0;
            cfg_data    = 32'hDEAD_BEEF;
            wr_result   = waiting && (cyc == resp_cyc);
            test_result = wr_result ? resp_res[cur_k] : 1'b0;
            seq_abort   = waiting && (cur_k == abort_at) && (cyc == start_cyc + 3);
            step();
        end
        seq_start = 1'b0;
        cfg_wr    = 1'b0;
        wr_result = 1'b0;
        seq_abort = 1'b0;
        check({tag, " finished"}, 64'(finished), 64'(1));
        check({tag, " n_starts"}, 64'(n_start), 64'(exp_starts));
        check({tag, " n_done"}, 64'(n_done), 64'(1));
        check({tag, " done_time"}, 64'(done_cyc), 64'(exp_starts == 0 ? 1 : last_wait_end + 1));
        check({tag, " busy_cycles"}, 64'(busy_cyc), 64'(done_cyc));
        check({tag, " fail_map"}, 64'(fail_map), 64'(exp_map));
        check({tag, " fail_cnt"}, 64'(fail_cnt), 64'(popcount8(exp_map)));
        check({tag, " timeout"}, 64'(timeout), 64'(exp_to));
        check({tag, " aborted"}, 64'(aborted), 64'(exp_ab));
        if (exp_starts > 0) begin
            check({tag, " final_idx"}, 64'(cur_idx), 64'(exp_starts - 1));
            check({tag, " final_params"}, test_param_reg, model_tbl[exp_starts - 1]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " start"}, 64'(start_test), 64'(0));
        check({tag, " done"}, 64'(done), 64'(0));
        check({tag, " params"}, test_param_reg, 64'(0));
        check({tag, " cur_idx"}, 64'(cur_idx), 64'(0));
        check({tag, " fail_map"}, 64'(fail_map), 64'(0));
        check({tag, " fail_cnt"}, 64'(fail_cnt), 64'(0));
        check({tag, " timeout"}, 64'(timeout), 64'(0));
        check({tag, " aborted"}, 64'(aborted), 64'(0));
    endtask

    vec_t vecs [7];

    initial begin
        int         n_exp;
        logic [7:0] map_exp;
        bit         to_exp;
        bit         ab_exp;
        bit         got;
        int         quiet_busy;

        vecs[0] = '{len: 3,  delay: 50, res: 8'h02, withhold: -1, abort_at: -1,
                    exp_starts: 3, exp_map: 8'h02, exp_timeout: 0, exp_aborted: 0};
        vecs[1] = '{len: 0,  delay: 10, res: 8'h00, withhold: -1, abort_at: -1,
                    exp_starts: 0, exp_map: 8'h00, exp_timeout: 0, exp_aborted: 0};
        vecs[2] = '{len: 12, delay: 10, res: 8'h81, withhold: -1, abort_at: -1,
                    exp_starts: 8, exp_map: 8'h81, exp_timeout: 0, exp_aborted: 0};
        vecs[3] = '{len: 4,  delay: 12, res: 8'h00, withhold: 1,  abort_at: -1,
                    exp_starts: 4, exp_map: 8'h02, exp_timeout: 1, exp_aborted: 0};
        vecs[4] = '{len: 4,  delay: 20, res: 8'h02, withhold: -1, abort_at: 1,
                    exp_starts: 2, exp_map: 8'h02, exp_timeout: 0, exp_aborted: 1};
        vecs[5] = '{len: 8,  delay: 6,  res: 8'h80, withhold: -1, abort_at: 7,
                    exp_starts: 8, exp_map: 8'h80, exp_timeout: 0, exp_aborted: 1};
        vecs[6] = '{len: 5,  delay: 8,  res: 8'h1F, withhold: 4,  abort_at: -1,
                    exp_starts: 5, exp_map: 8'h1F, exp_timeout: 1, exp_aborted: 0};

        rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_word = 1'b0; cfg_data = '0;
        seq_len = '0; seq_start = 1'b0; seq_abort = 1'b0; wr_result = 1'b0; test_result = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < int'(DEPTH); i++) write_entry(i, 32'h1000_0000 + i, $urandom);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                resp_delay[i] = (i == vecs[v].withhold) ? 0 : vecs[v].delay;
                resp_res[i]   = vecs[v].res[i];
            end
            run_seq($sformatf("vec%0d", v), vecs[v].len, vecs[v].abort_at, vecs[v].exp_starts,
                    vecs[v].exp_map, vecs[v].exp_timeout, vecs[v].exp_aborted);
            step();
        end

        // Stray result strobe while idle must not touch the recorded map.
        wr_result = 1'b1; test_result = 1'b1;
        step();
        wr_result = 1'b0; test_result = 1'b0;
        step();
        check("stray_wr fail_map", 64'(fail_map), 64'(vecs[6].exp_map));
        check("stray_wr fail_cnt", 64'(fail_cnt), 64'(popcount8(vecs[6].exp_map)));

        // Start together with abort in idle is ignored.
        seq_start = 1'b1; seq_abort = 1'b1; seq_len = 4'd3;
        step();
        seq_start = 1'b0; seq_abort = 1'b0;
        quiet_busy = 0;
        for (int c = 0; c < 6; c++) begin
            if (busy || start_test) quiet_busy++;
            step();
        end
        check("start_with_abort ignored", 64'(quiet_busy), 64'(0));

        for (int r = 0; r < 6; r++) begin
            int len_r;
            int ab_r;
            write_entry($urandom_range(0, DEPTH - 1), $urandom, $urandom);
            len_r = $urandom_range(0, 11);
            ab_r  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                resp_delay[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 40));
                resp_res[i]   = 1'($urandom_range(0, 1));
            end
            model_expect(len_r, ab_r, n_exp, map_exp, to_exp, ab_exp);
            run_seq($sformatf("rnd%0d", r), len_r, ab_r, n_exp, map_exp, to_exp, ab_exp);
            step();
        end

        // Reset while waiting on entry 1.
        seq_start = 1'b1; seq_len = 4'd2;
        step();
        seq_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (start_test) got = 1'b1;
            else step();
        end
        check("rst_seq first_start", 64'(got), 64'(1));
        for (int c = 0; c < 5; c++) step();
        wr_result = 1'b1; test_result = 1'b1;
        step();
        wr_result = 1'b0; test_result = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (start_test) got = 1'b1;
            else step();
        end
        check("rst_seq second_start", 64'(got), 64'(1));
        step(); step(); step();
        check("rst_seq pre busy", 64'(busy), 64'(1));
        check("rst_seq pre cur_idx", 64'(cur_idx), 64'(1));
        rst = 1'b1;
        step();
        check_all_zero("rst_in_wait");
        rst = 1'b0;
        step();
        check("rst_seq stays idle", 64'(busy), 64'(0));

        // Table survives reset.
        for (int i = 0; i < int'(DEPTH); i++) begin
            resp_delay[i] = 5;
            resp_res[i]   = 1'b0;
        end
        run_seq("post_rst", 2, -1, 2, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
